onehot_scan_decoder: RTL and testbench
======================================

# onehot_scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with two operating modes. In direct mode it decodes `sel_in` every cycle. In scan mode it holds an internal index that is loaded once and then stepped up or down with wrap-around, producing a rotating one-hot select. It sits between control logic and banks of enables (row/bank selects, channel strobes) and replaces the combinational 3:8 decoder where a registered, glitch-free, sequenceable select is required.

## Interface
Parameters:
- `SEL_W`, 3, select width; output width is `OUT_W = 2**SEL_W` (legal 1..6).
- `ACT_LOW`, 0, when 1 every bit of `dec_out` is inverted; the inactive pattern is then all ones.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  block enable; 0 forces IDLE.
- `mode`  in  1  0 = DIRECT, 1 = SCAN.
- `load`  in  1  loads `idx` from `sel_in`; also arms the block out of IDLE.
- `step`  in  1  in SCAN, advance `idx` by one position.
- `dir`  in  1  scan direction: 0 = up (+1), 1 = down (−1).
- `sel_in`  in  SEL_W  select / load value.
- `dec_out`  out  OUT_W  registered one-hot (or one-cold when `ACT_LOW`=1) output.
- `idx`  out  SEL_W  current registered index.
- `valid`  out  1  1 when `dec_out` holds an active decode.
- `wrap`  out  1  one-cycle pulse when a scan step wraps.

## Operation
- State machine states:
  - IDLE: inactive output, `valid`=0.
  - DIRECT: decode of `sel_in` each cycle.
  - SCAN: decode of the internal index.
- Per-cycle priority: `en`=0, then `load`, then `mode` switch, then `step`.
- IDLE transitions:
  - Stays in IDLE unless `en`=1 and `load`=1.
  - On that condition, `idx` ← `sel_in` and the state becomes DIRECT if `mode`=0, SCAN if `mode`=1.
  - `step` is ignored in IDLE.
- DIRECT:
  - `idx` ← `sel_in` every cycle.
  - `mode`=1 moves to SCAN, keeping the current `sel_in` as `idx`.
  - `step` and `dir` are ignored.
- SCAN:
  - `load`=1: `idx` ← `sel_in`, no wrap.
  - Otherwise `step`=1 with `dir`=0: `idx` ← `idx`+1 modulo `OUT_W`.
  - Otherwise `step`=1 with `dir`=1: `idx` ← `idx`−1 modulo `OUT_W`.
  - `mode`=0 moves to DIRECT; `idx` ← `sel_in` on that same edge.
- Any active state with `en`=0 moves to IDLE. `idx` retains its value; the output goes inactive.
- `dec_out` update: `dec_out` ← (1 << next `idx`) when the next state is not IDLE, else 0. The result is XORed with all ones when `ACT_LOW`=1. Exactly one bit is active whenever `valid`=1.
- `wrap` is registered and set only for a SCAN step that is not overridden by `load`, `mode` or `en`:
  - up-step from `OUT_W`−1 to 0;
  - down-step from 0 to `OUT_W`−1.
  - 0 in all other cycles.
- `SEL_W`-bit index arithmetic; wrap-around comes from natural overflow/underflow.

## Timing
- Reset (asynchronous assert, synchronous release by flop nature):
  - state = IDLE, `idx`=0, `valid`=0, `wrap`=0.
  - `dec_out`=0 (all ones when `ACT_LOW`=1).
- Latency: one clock from a sampled input to `dec_out`/`idx`/`valid`/`wrap`. No combinational input-to-output path.
- `step` held high advances one position per cycle, continuously.
- `load` and `step` in the same cycle: the load wins and the step is dropped.
- `en` falling: output is inactive from the next edge; a simultaneous `step`/`load` is discarded.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously); `idx` is lost.
- `valid` rises in the cycle after the arming `load` and falls in the cycle after `en` goes low.

## Test plan
All scenarios use `SEL_W`=3 unless stated.
- Reset, then idle stimulus: `rst_n`=0 mid-run with `dec_out`=8'b0010_0000 -> immediately `dec_out`=0, `idx`=0, `valid`=0. With `en`=1, `step`=1 and `load`=0 in IDLE -> outputs stay 0.
- DIRECT sweep: `en`=1, `load`=1 at cycle 0, `mode`=0, then `sel_in`=0..7 one per cycle -> `dec_out`=1<<`sel_in` one cycle later each time; `valid`=1 from cycle 1; `wrap` never set.
- SCAN up with wrap: load `sel_in`=6, `mode`=1, `step`=1, `dir`=0 held -> `idx` sequence 6,7,0,1; `dec_out` 0x40,0x80,0x01,0x02; `wrap`=1 only in the cycle `idx` becomes 0.
- SCAN down with wrap: load 1, `dir`=1, `step` held -> `idx` 1,0,7,6; `wrap`=1 with `idx`=7.
- Priority corner: in SCAN at `idx`=7 with `load`=1, `sel_in`=3 and `step`=1 -> `idx`=3, `wrap`=0. Next cycle `en`=0 with `step`=1 -> `dec_out`=0, `valid`=0, `idx` held at 3.
- `ACT_LOW`=1, `SEL_W`=2: reset -> `dec_out`=4'b1111; load 2 in DIRECT -> 4'b1011.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct mode (decode sel_in every
// cycle) and a scan mode (loadable index stepped up/down with wrap-around).
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter bit ACT_LOW = 1'b0,
  localparam int OUT_W  = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic             step,
  input  logic             dir,
  input  logic [SEL_W-1:0] sel_in,
  output logic [OUT_W-1:0] dec_out,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   dec_q, dec_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            idx_d   = sel_in;
            state_d = mode ? SCAN : DIRECT;
          end
        end
        DIRECT: begin
          idx_d   = sel_in;
          state_d = mode ? SCAN : DIRECT;
        end
        SCAN: begin
          if (load) begin
            idx_d   = sel_in;
            state_d = mode ? SCAN : DIRECT;
          end else if (!mode) begin
            idx_d   = sel_in;
            state_d = DIRECT;
          end else if (step) begin
            // Natural SEL_W-bit overflow provides the modulo OUT_W wrap.
            if (dir) begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end else begin
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == '1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d != IDLE);
    dec_d   = '0;
    if (valid_d) dec_d[idx_d] = 1'b1;
    dec_d   = dec_d ^ {OUT_W{ACT_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dec_q   <= {OUT_W{ACT_LOW}};
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dec_out = dec_q;
  assign idx     = idx_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: a vector table for the 3-bit
// active-high instance plus hand sequences for async reset and ACT_LOW.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, load, step, dir;
  logic [2:0] sel;
  logic [1:0] sel_lo;
  logic [7:0] dec;
  logic [2:0] idx;
  logic       valid, wrap;
  logic [3:0] dec_lo;
  logic [1:0] idx_lo;
  logic       valid_lo, wrap_lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(3), .ACT_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .step(step), .dir(dir), .sel_in(sel),
    .dec_out(dec), .idx(idx), .valid(valid), .wrap(wrap)
  );

  onehot_scan_decoder #(.SEL_W(2), .ACT_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .step(step), .dir(dir), .sel_in(sel_lo),
    .dec_out(dec_lo), .idx(idx_lo), .valid(valid_lo), .wrap(wrap_lo)
  );

  typedef struct {
    logic       en, mode, load, step, dir;
    logic [2:0] sel;
    logic [7:0] e_dec;
    logic [2:0] e_idx;
    logic       e_valid, e_wrap;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  task automatic add(input logic e, m, l, s, d, input logic [2:0] sl,
                     input logic [7:0] xd, input logic [2:0] xi,
                     input logic xv, xw);
    vecs[nv] = '{e, m, l, s, d, sl, xd, xi, xv, xw};
    nv++;
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; mode = 0; load = 0; step = 0; dir = 0;
    sel = '0; sel_lo = '0;

    //   en m  l  s  d  sel   dec     idx  v  w
    add(1, 0, 0, 1, 0, 3'd5, 8'h00, 3'd0, 0, 0); // step ignored in IDLE
    add(1, 0, 1, 0, 0, 3'd0, 8'h01, 3'd0, 1, 0); // arm into DIRECT
    for (int s = 1; s < 8; s++)
      add(1, 0, 0, s[0], 1, 3'(s), 8'(1 << s), 3'(s), 1, 0);
    add(1, 1, 1, 1, 0, 3'd6, 8'h40, 3'd6, 1, 0); // load beats step
    add(1, 1, 0, 1, 0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(1, 1, 0, 1, 0, 3'd0, 8'h01, 3'd0, 1, 1); // up wrap
    add(1, 1, 0, 1, 0, 3'd0, 8'h02, 3'd1, 1, 0);
    add(1, 1, 1, 1, 1, 3'd1, 8'h02, 3'd1, 1, 0);
    add(1, 1, 0, 1, 1, 3'd4, 8'h01, 3'd0, 1, 0);
    add(1, 1, 0, 1, 1, 3'd4, 8'h80, 3'd7, 1, 1); // down wrap
    add(1, 1, 0, 1, 1, 3'd4, 8'h40, 3'd6, 1, 0);
    add(1, 1, 0, 1, 0, 3'd4, 8'h80, 3'd7, 1, 0);
    add(1, 1, 1, 1, 0, 3'd3, 8'h08, 3'd3, 1, 0); // load at 7: no wrap
    add(0, 1, 0, 1, 0, 3'd6, 8'h00, 3'd3, 0, 0); // en drop, step dropped
    add(0, 1, 1, 0, 0, 3'd5, 8'h00, 3'd3, 0, 0); // load ignored while disabled
    add(1, 1, 1, 0, 0, 3'd2, 8'h04, 3'd2, 1, 0);
    add(1, 0, 0, 1, 0, 3'd5, 8'h20, 3'd5, 1, 0); // SCAN -> DIRECT takes sel_in
    add(1, 1, 0, 1, 0, 3'd4, 8'h10, 3'd4, 1, 0); // DIRECT -> SCAN keeps sel_in
    add(1, 1, 0, 1, 0, 3'd0, 8'h20, 3'd5, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dec", 0, 32'(dec), 32'h00);
    chk("rst_idx", 0, 32'(idx), 32'h0);
    chk("rst_valid", 0, 32'(valid), 32'h0);
    chk("rst_wrap", 0, 32'(wrap), 32'h0);
    chk("rst_dec_lo", 0, 32'(dec_lo), 32'hF);
    rst_n = 1'b1;

    for (int k = 0; k < nv; k++) begin
      en = vecs[k].en; mode = vecs[k].mode; load = vecs[k].load;
      step = vecs[k].step; dir = vecs[k].dir; sel = vecs[k].sel;
      sel_lo = vecs[k].sel[1:0];
      @(posedge clk);
      #1;
      chk("dec", k, 32'(dec), 32'(vecs[k].e_dec));
      chk("idx", k, 32'(idx), 32'(vecs[k].e_idx));
      chk("valid", k, 32'(valid), 32'(vecs[k].e_valid));
      chk("wrap", k, 32'(wrap), 32'(vecs[k].e_wrap));
    end

    // Asynchronous reset mid-scan while dec_out = 0x20.
    chk("pre_async_dec", 0, 32'(dec), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dec", 0, 32'(dec), 32'h00);
    chk("async_idx", 0, 32'(idx), 32'h0);
    chk("async_valid", 0, 32'(valid), 32'h0);
    chk("async_dec_lo", 0, 32'(dec_lo), 32'hF);
    chk("async_idx_lo", 0, 32'(idx_lo), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-cold instance: load 2 in DIRECT.
    en = 1; mode = 0; load = 1; step = 0; dir = 0; sel = 3'd1; sel_lo = 2'd2;
    @(posedge clk);
    #1;
    chk("low_dec", 0, 32'(dec_lo), 32'hB);
    chk("low_idx", 0, 32'(idx_lo), 32'h2);
    chk("low_valid", 0, 32'(valid_lo), 32'h1);
    chk("hi_dec", 0, 32'(dec), 32'h02);
    en = 0; load = 0;
    @(posedge clk);
    #1;
    chk("low_off_dec", 0, 32'(dec_lo), 32'hF);
    chk("low_off_valid", 0, 32'(valid_lo), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
